// File: rtl/pe_pkg_arb_pkg.sv
// Shared types and default sizing for the packed-row arbiter.
package pe_pkg_arb_pkg;

    typedef enum logic {
        StIdle = 1'b0,
        StRun  = 1'b1
    } state_e;

    localparam int unsigned DefRows       = 4;
    localparam int unsigned DefTbits      = 64;
    localparam int unsigned DefFrameWords = 16;
    localparam int unsigned DefAw         = 10;

endpackage

// File: rtl/pe_pkg_fifo2.sv
// Two-entry FIFO with head-at-entry-0 layout; push while full is legal only with a pop.
module pe_pkg_fifo2 #(
    parameter int unsigned W = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         empty,
    output logic         full
);

    logic [1:0]   cnt_q;
    logic [W-1:0] mem0_q, mem1_q;

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem0_q <= '0;
            mem1_q <= '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (cnt_q == 2'd0) mem0_q <= din;
                    else               mem1_q <= din;
                end
                2'b01: mem0_q <= mem1_q;
                2'b11: begin
                    // With one entry the pushed word becomes the new head.
                    if (cnt_q == 2'd1) begin
                        mem0_q <= din;
                    end else begin
                        mem0_q <= mem1_q;
                        mem1_q <= din;
                    end
                end
                default: ;
            endcase
        end
    end

    assign dout  = mem0_q;
    assign empty = (cnt_q == 2'd0);
    assign full  = (cnt_q == 2'd2);

endmodule

// File: rtl/pe_pkg_arb.sv
// Collects per-row packed words into small FIFOs and drains them round-robin into a
// single output register that addresses a frame buffer laid out row-major.
module pe_pkg_arb
    import pe_pkg_arb_pkg::*;
#(
    parameter int unsigned ROWS        = DefRows,
    parameter int unsigned TBITS       = DefTbits,
    parameter int unsigned FRAME_WORDS = DefFrameWords,
    parameter int unsigned AW          = DefAw
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ROWS-1:0]       row_valid,
    input  logic [ROWS*TBITS-1:0] row_data,
    output logic                  dout_valid,
    input  logic                  dout_ready,
    output logic [TBITS-1:0]      dout_data,
    output logic [AW-1:0]         dout_addr,
    output logic                  busy,
    output logic                  done,
    output logic [ROWS-1:0]       ovf
);

    localparam int unsigned PW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int unsigned CW = $clog2(FRAME_WORDS + 1);
    localparam logic [CW-1:0] FullCnt = CW'(FRAME_WORDS);

    state_e            state_q, state_d;
    logic              done_q, done_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [ROWS-1:0]   ovf_q, ovf_d;
    logic [CW-1:0]     cnt_q [ROWS];
    logic [CW-1:0]     cnt_d [ROWS];
    logic [CW-1:0]     idx_q [ROWS];
    logic [CW-1:0]     idx_d [ROWS];
    logic              out_valid_q, out_valid_d;
    logic [TBITS-1:0]  out_data_q, out_data_d;
    logic [AW-1:0]     out_addr_q, out_addr_d;

    logic              clr;
    logic [ROWS-1:0]   f_push, f_pop, f_empty, f_full, drop;
    logic [TBITS-1:0]  f_head [ROWS];
    logic              gnt_valid;
    logic [PW-1:0]     gnt_row, cand;
    logic              all_done;

    for (genvar r = 0; r < ROWS; r++) begin : g_fifo
        pe_pkg_fifo2 #(
            .W(TBITS)
        ) u_fifo (
            .clk  (clk),
            .reset(reset),
            .clr  (clr),
            .push (f_push[r]),
            .pop  (f_pop[r]),
            .din  (row_data[r*TBITS +: TBITS]),
            .dout (f_head[r]),
            .empty(f_empty[r]),
            .full (f_full[r])
        );
    end

    // Round-robin search starting at ptr_q, only when the output register can load.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_row   = '0;
        cand      = '0;
        f_pop     = '0;
        if (state_q == StRun && (!out_valid_q || dout_ready)) begin
            for (int unsigned i = 0; i < ROWS; i++) begin
                cand = PW'((32'(ptr_q) + i) % ROWS);
                if (!gnt_valid && !f_empty[cand]) begin
                    gnt_valid = 1'b1;
                    gnt_row   = cand;
                end
            end
        end
        if (gnt_valid) f_pop[gnt_row] = 1'b1;
    end

    always_comb begin
        all_done = (state_q == StRun) && !out_valid_q;
        for (int unsigned r = 0; r < ROWS; r++) begin
            f_push[r] = (state_q == StRun) && row_valid[r] && (cnt_q[r] != FullCnt) &&
                        (!f_full[r] || f_pop[r]);
            drop[r]   = row_valid[r] && !f_push[r];
            if (cnt_q[r] != FullCnt || !f_empty[r]) all_done = 1'b0;
        end
    end

    always_comb begin
        state_d     = state_q;
        done_d      = 1'b0;
        ptr_d       = ptr_q;
        ovf_d       = ovf_q | drop;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_addr_d  = out_addr_q;
        clr         = 1'b0;
        if (out_valid_q && dout_ready) out_valid_d = 1'b0;
        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StRun;
                    clr     = 1'b1;
                    ovf_d   = '0;
                    ptr_d   = '0;
                    for (int unsigned r = 0; r < ROWS; r++) begin
                        cnt_d[r] = '0;
                        idx_d[r] = '0;
                    end
                end
            end
            StRun: begin
                for (int unsigned r = 0; r < ROWS; r++) begin
                    if (f_push[r]) cnt_d[r] = cnt_q[r] + CW'(1);
                end
                if (gnt_valid) begin
                    out_valid_d     = 1'b1;
                    out_data_d      = f_head[gnt_row];
                    out_addr_d      = AW'(32'(gnt_row) * FRAME_WORDS + 32'(idx_q[gnt_row]));
                    idx_d[gnt_row]  = idx_q[gnt_row] + CW'(1);
                    ptr_d           = (gnt_row == PW'(ROWS - 1)) ? '0 : gnt_row + PW'(1);
                end
                if (all_done) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            done_q      <= 1'b0;
            ptr_q       <= '0;
            ovf_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_addr_q  <= '0;
            for (int unsigned r = 0; r < ROWS; r++) begin
                cnt_q[r] <= '0;
                idx_q[r] <= '0;
            end
        end else begin
            state_q     <= state_d;
            done_q      <= done_d;
            ptr_q       <= ptr_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_addr_q  <= out_addr_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
        end
    end

    assign dout_valid = out_valid_q;
    assign dout_data  = out_data_q;
    assign dout_addr  = out_addr_q;
    assign busy       = (state_q == StRun);
    assign done       = done_q;
    assign ovf        = ovf_q;

endmodule

// File: tb/tb_pe_pkg_arb.sv
// Directed bench for pe_pkg_arb with a queue-based frame model checked every cycle.
module tb_pe_pkg_arb;

    localparam int ROWS = 4;
    localparam int TB   = 64;
    localparam int FW   = 16;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic [ROWS-1:0]  row_valid = '0;
    logic [ROWS*TB-1:0] row_data = '0;
    logic             dout_valid;
    logic             dout_ready = 1'b1;
    logic [TB-1:0]    dout_data;
    logic [9:0]       dout_addr;
    logic             busy, done;
    logic [ROWS-1:0]  ovf;

    int vectors = 0;
    int miscompares = 0;
    int done_seen = 0;
    logic busy_at_done = 1'b1;

    logic [9:0]  log_addr [$];
    logic [63:0] log_data [$];

    // Model state: per-row pending queues plus frame bookkeeping.
    bit          m_run = 0;
    logic [63:0] mq [ROWS][$];
    int          m_cnt [ROWS];
    int          m_idx [ROWS];
    int          m_ptr = 0;
    bit          m_valid = 0;
    logic [63:0] m_data = '0;
    int          m_addr = 0;
    bit          m_done = 0;
    logic [ROWS-1:0] m_ovf = '0;

    pe_pkg_arb u_dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .row_valid (row_valid),
        .row_data  (row_data),
        .dout_valid(dout_valid),
        .dout_ready(dout_ready),
        .dout_data (dout_data),
        .dout_addr (dout_addr),
        .busy      (busy),
        .done      (done),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_next();
        bit acc;
        bit done_now;
        int gnt;
        acc = m_valid && dout_ready;
        if (reset) begin
            m_run = 0; m_ptr = 0; m_valid = 0; m_done = 0; m_ovf = '0;
            for (int r = 0; r < ROWS; r++) begin
                mq[r].delete(); m_cnt[r] = 0; m_idx[r] = 0;
            end
            return;
        end
        m_done = 0;
        if (!m_run) begin
            if (acc) m_valid = 0;
            for (int r = 0; r < ROWS; r++) if (row_valid[r]) m_ovf[r] = 1'b1;
            if (start) begin
                m_run = 1; m_ptr = 0; m_ovf = '0;
                for (int r = 0; r < ROWS; r++) begin
                    mq[r].delete(); m_cnt[r] = 0; m_idx[r] = 0;
                end
            end
            return;
        end
        done_now = !m_valid;
        for (int r = 0; r < ROWS; r++)
            if (m_cnt[r] != FW || mq[r].size() != 0) done_now = 0;
        gnt = -1;
        if (!m_valid || dout_ready) begin
            for (int i = 0; i < ROWS; i++) begin
                int r;
                r = (m_ptr + i) % ROWS;
                if (gnt < 0 && mq[r].size() > 0) gnt = r;
            end
        end
        if (acc) m_valid = 0;
        if (gnt >= 0) begin
            m_data = mq[gnt].pop_front();
            m_addr = (gnt * FW + m_idx[gnt]) % 1024;
            m_idx[gnt]++;
            m_valid = 1;
            m_ptr = (gnt + 1) % ROWS;
        end
        for (int r = 0; r < ROWS; r++) begin
            if (row_valid[r]) begin
                if (m_cnt[r] < FW && mq[r].size() < 2) begin
                    mq[r].push_back(row_data[r*TB +: TB]);
                    m_cnt[r]++;
                end else begin
                    m_ovf[r] = 1'b1;
                end
            end
        end
        if (done_now) begin
            m_run = 0;
            m_done = 1;
        end
    endtask

    // Sample pre-edge inputs just before each rising edge, compare just after it.
    always begin
        @(negedge clk);
        #4;
        if (!reset && dout_valid && dout_ready) begin
            log_addr.push_back(dout_addr);
            log_data.push_back(dout_data);
        end
        model_next();
        @(posedge clk);
        #1;
        chk("dout_valid", dout_valid, m_valid);
        if (m_valid && dout_valid) begin
            chk("dout_data", dout_data, m_data);
            chk("dout_addr", dout_addr, 10'(m_addr));
        end
        chk("busy", busy, m_run);
        chk("done", done, m_done);
        chk("ovf", ovf, m_ovf);
        if (done) begin
            done_seen++;
            busy_at_done = busy;
        end
    end

    task automatic drive(input logic [3:0] v, input logic [63:0] d0, input logic [63:0] d1,
                         input logic [63:0] d2, input logic [63:0] d3);
        row_valid = v;
        row_data  = {d3, d2, d1, d0};
        @(negedge clk);
        row_valid = '0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_log(input string nm, input int i, input logic [9:0] a,
                           input logic [63:0] d);
        chk({nm, "_addr"}, (i < log_addr.size()) ? log_addr[i] : 10'h3ff, a);
        chk({nm, "_data"}, (i < log_data.size()) ? log_data[i] : 64'hdead, d);
    endtask

    initial begin
        int base;
        int d_before;
        idle(3);
        chk("rst_dout_valid", dout_valid, 1'b0);
        chk("rst_dout_data", dout_data, 64'h0);
        chk("rst_dout_addr", dout_addr, 10'h0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_ovf", ovf, 4'h0);
        reset = 1'b0;
        idle(1);

        // Frame 1: row 0 streams A0..A15 back to back.
        pulse_start();
        chk("busy_after_start", busy, 1'b1);
        for (int i = 0; i < FW; i++) drive(4'b0001, 64'hA0A0_0000_0000_0000 + 64'(i), 0, 0, 0);
        idle(4);
        chk("row0_count", 32'(log_addr.size()), 32'd16);
        for (int i = 0; i < FW; i++)
            chk_log("row0", i, 10'(i), 64'hA0A0_0000_0000_0000 + 64'(i));
        chk("row0_ovf", ovf, 4'h0);
        chk("row0_no_done", 32'(done_seen), 32'd0);

        // 17th word on row 0 is refused.
        drive(4'b0001, 64'hA0A0_0000_0000_0010, 0, 0, 0);
        chk("row0_17th_ovf", ovf, 4'b0001);

        // Rows 1..3 complete at a pace the output can drain.
        for (int i = 0; i < FW; i++) begin
            drive(4'b1110, 0, 64'hB000 + 64'(i), 64'hC000 + 64'(i), 64'hD000 + 64'(i));
            idle(2);
        end
        for (int i = 0; i < 300 && done_seen == 0; i++) @(negedge clk);
        chk("frame1_done_once", 32'(done_seen), 32'd1);
        chk("busy_low_at_done", busy_at_done, 1'b0);
        idle(3);
        chk("frame1_single_done", 32'(done_seen), 32'd1);
        chk("frame1_words", 32'(log_addr.size()), 32'd64);

        // Frame 2: all rows in the same cycle.
        pulse_start();
        chk("ovf_cleared", ovf, 4'h0);
        base = log_addr.size();
        drive(4'b1111, 64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
              64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444);
        idle(6);
        chk_log("rr0", base + 0, 10'd0,  64'h1111_1111_1111_1111);
        chk_log("rr1", base + 1, 10'd16, 64'h2222_2222_2222_2222);
        chk_log("rr2", base + 2, 10'd32, 64'h3333_3333_3333_3333);
        chk_log("rr3", base + 3, 10'd48, 64'h4444_4444_4444_4444);

        // Stalled output: row 1 fills the register, row 2's third word is lost.
        dout_ready = 1'b0;
        base = log_addr.size();
        drive(4'b0010, 0, 64'hB1, 0, 0);
        drive(4'b0100, 0, 0, 64'hC1, 0);
        drive(4'b0100, 0, 0, 64'hC2, 0);
        drive(4'b0100, 0, 0, 64'hC3, 0);
        idle(2);
        chk("stall_ovf2", ovf, 4'b0100);
        chk("stall_valid_held", dout_valid, 1'b1);
        chk("stall_addr_held", dout_addr, 10'd17);
        dout_ready = 1'b1;
        idle(6);
        chk("stall_count", 32'(log_addr.size() - base), 32'd3);
        chk_log("stall_b1", base + 0, 10'd17, 64'hB1);
        chk_log("stall_c1", base + 1, 10'd33, 64'hC1);
        chk_log("stall_c2", base + 2, 10'd34, 64'hC2);

        // Reset with words buffered mid-frame.
        d_before = done_seen;
        dout_ready = 1'b0;
        drive(4'b1001, 64'hD0, 0, 0, 64'hD3);
        drive(4'b1001, 64'hE0, 0, 0, 64'hE3);
        chk("pre_reset_valid", dout_valid, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        chk("reset_dout_valid", dout_valid, 1'b0);
        chk("reset_busy", busy, 1'b0);
        reset = 1'b0;
        dout_ready = 1'b1;
        idle(3);
        chk("reset_no_done", 32'(done_seen), 32'(d_before));
        base = log_addr.size();
        pulse_start();
        drive(4'b0001, 64'hF0, 0, 0, 0);
        idle(4);
        chk("restart_count", 32'(log_addr.size() - base), 32'd1);
        chk_log("restart", base, 10'd0, 64'hF0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
